// File: rtl/regfile_write_buffer_if.sv
// Handshake, write-port and read-forwarding signals between the write-back
// stage, the register-file write buffer and the register file itself.
interface regfile_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          rf_write;
  logic [AW-1:0] rf_wreg;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rf_o1;
  logic [DW-1:0] rf_o2;
  logic [DW-1:0] fwd_o1;
  logic [DW-1:0] fwd_o2;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_addr, in_data, drain_en, rd_addr1, rd_addr2, rf_o1, rf_o2,
    input  in_ready, rf_write, rf_wreg, rf_wdata, fwd_o1, fwd_o2, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, rd_addr1, rd_addr2, rf_o1, rf_o2,
    output in_ready, rf_write, rf_wreg, rf_wdata, fwd_o1, fwd_o2, count
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// Small FIFO of pending register writes, drained one per cycle onto the
// register file write port, with youngest-wins forwarding onto both read paths.
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  regfile_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          ready;
  logic          push;
  logic          store;
  logic          pop;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;

  always_comb begin
    ready    = (count_q < CW'(DEPTH));
    push     = bus.in_valid && ready;
    // Writes to r0 complete the handshake but are dropped.
    store    = push && (bus.in_addr != '0);
    pop      = (count_q != '0) && bus.drain_en;

    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (store) begin
      addr_d[wr_ptr_q] = bus.in_addr;
      data_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(store) - CW'(pop);
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    fwd1 = bus.rf_o1;
    fwd2 = bus.rf_o2;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if ((bus.rd_addr1 != '0) && (addr_q[idx] == bus.rd_addr1)) fwd1 = data_q[idx];
        if ((bus.rd_addr2 != '0) && (addr_q[idx] == bus.rd_addr2)) fwd2 = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.rf_write = pop;
  assign bus.rf_wreg  = addr_q[rd_ptr_q];
  assign bus.rf_wdata = data_q[rd_ptr_q];
  assign bus.fwd_o1   = fwd1;
  assign bus.fwd_o2   = fwd2;
  assign bus.count    = count_q;
endmodule
